// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//
// IF/ID pipeline register between the instruction fetch unit and the decoder.
// Carries fetch address, instruction word and the hit_fetch sideband flag.
// Adds a valid/ready handshake on both sides, a one-entry skid buffer so
// in_ready can be registered without losing words, a flush that drops
// everything (held and incoming) and leaves a bubble, a next-PC output, and
// a saturating count of cycles the decoder held back a valid word.
//
// All state changes on the FALLING edge of clk; rst_n is asynchronous,
// active-low.
//
// Ports
//   clk            in   1        clock (state updates on negedge)
//   rst_n          in   1        asynchronous active-low reset
//   in_valid       in   1        fetch presents a word
//   in_ready       out  1        stage can accept a word (registered)
//   addr_in        in   ADDR_W   fetch address
//   instr_in       in   INSTR_W  fetched instruction
//   hit_fetch_in   in   1        cache-hit flag, travels with its word
//   flush          in   1        discard held and incoming words
//   out_valid      out  1        decode-side word valid
//   out_ready      in   1        decoder accepts the word
//   addr_out       out  ADDR_W   held address
//   instr_out      out  INSTR_W  held instruction, NOP_INSTR when empty
//   hit_fetch_out  out  1        held hit flag, 0 when empty
//   addr_next_out  out  ADDR_W   addr_out + PC_INC (wraps)
//   stall_cnt      out  CNT_W    saturating back-pressure cycle count
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_INC    = 1,
  parameter int                 CNT_W     = 8,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               hit_fetch_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               hit_fetch_out,
  output logic [ADDR_W-1:0]  addr_next_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Main entry: drives the decode-side outputs directly.
  logic               main_valid_q, main_valid_d;
  logic [ADDR_W-1:0]  main_addr_q,  main_addr_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               main_hit_q,   main_hit_d;

  // Skid entry: catches the word accepted in the cycle the decoder stalls,
  // since in_ready is registered and cannot drop in that same cycle.
  logic               skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]  skid_addr_q,  skid_addr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               skid_hit_q,   skid_hit_d;

  logic               in_ready_q,   in_ready_d;
  logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

  logic push;
  logic pop;

  assign push = in_valid  & in_ready_q;
  assign pop  = main_valid_q & out_ready;

  // Next-state logic. The main entry is cleared to address 0 / NOP_INSTR /
  // hit 0 whenever it empties, so the outputs can come straight from the
  // registers without a separate masking stage.
  always_comb begin
    main_valid_d = main_valid_q;
    main_addr_d  = main_addr_q;
    main_instr_d = main_instr_q;
    main_hit_d   = main_hit_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_instr_d = skid_instr_q;
    skid_hit_d   = skid_hit_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      // Flush wins over push and pop: both entries dropped, incoming word
      // ignored, a bubble is presented next.
      main_valid_d = 1'b0;
      main_addr_d  = '0;
      main_instr_d = NOP_INSTR;
      main_hit_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Empty stage: the skid is necessarily empty too.
      if (push) begin
        main_valid_d = 1'b1;
        main_addr_d  = addr_in;
        main_instr_d = instr_in;
        main_hit_d   = hit_fetch_in;
      end
    end else if (pop) begin
      if (skid_valid_q) begin
        // in_ready was low this cycle, so no push can coincide here.
        main_addr_d  = skid_addr_q;
        main_instr_d = skid_instr_q;
        main_hit_d   = skid_hit_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_addr_d  = addr_in;
        main_instr_d = instr_in;
        main_hit_d   = hit_fetch_in;
      end else begin
        main_valid_d = 1'b0;
        main_addr_d  = '0;
        main_instr_d = NOP_INSTR;
        main_hit_d   = 1'b0;
      end
    end else if (push) begin
      // Decoder stalled but we had advertised ready: park the word.
      skid_valid_d = 1'b1;
      skid_addr_d  = addr_in;
      skid_instr_d = instr_in;
      skid_hit_d   = hit_fetch_in;
    end

    // Accept again only once the skid slot is guaranteed free.
    in_ready_d = ~skid_valid_d;

    // Back-pressure cycles are counted on the pre-edge state; a flush edge
    // is not a stall because the held word is being discarded.
    if (main_valid_q && !out_ready && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_addr_q  <= '0;
      main_instr_q <= NOP_INSTR;
      main_hit_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_hit_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_addr_q  <= main_addr_d;
      main_instr_q <= main_instr_d;
      main_hit_q   <= main_hit_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_hit_q   <= skid_hit_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign addr_out      = main_addr_q;
  assign instr_out     = main_instr_q;
  assign hit_fetch_out = main_hit_q;
  assign stall_cnt     = stall_cnt_q;

  // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
  assign addr_next_out = main_addr_q + ADDR_W'(PC_INC);

endmodule
